// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer behind the SPI slave byte interface.
// Parses framed command bytes from the MOSI byte stream. Write frames store
// into a small byte-wide register file. Read frames return register contents
// as MISO bytes. Register 0 is read-only and always returns ID_VAL.
//
// Command byte: bit7 = write(1)/read(0), bit6 = auto-increment,
// bits[5:0] = address. Any set address bit at or above ADDR_W makes the
// frame illegal, and the rest of that frame is discarded.
//
// Byte handshake: a byte is consumed only in a cycle where mosi_vld_i=1 and
// cs_i=1. mosi_vld_i is a one-cycle strobe with no back-pressure. cs_i=0
// always wins: it aborts the frame on the next edge and drops any
// coincident byte.
//
// Optional build macro: SPI_REG_ERR_CNT_EN. When it is defined, err_cnt_o
// counts illegal command bytes and saturates at 8'hFF. When it is not
// defined, err_cnt_o is tied to 8'h00.
module spi_reg_ctrl #(
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic              Clk_p_w,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              mosi_vld_i,
    input  logic [7:0]        mosi_byte_i,
    output logic              miso_en_o,
    output logic [7:0]        miso_byte_o,
    output logic              wr_stb_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic [7:0]        err_cnt_o,
    output logic [1:0]        state_o
);

    localparam int         DEPTH     = 1 << ADDR_W;
    // Command address bits that must be zero for a legal frame.
    localparam logic [5:0] HI_MASK   = ~6'((1 << ADDR_W) - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              ai;
    logic [7:0]        regs [DEPTH];

    logic              byte_ev;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_illegal;
    logic [ADDR_W-1:0] addr_inc;
    logic              reg_we;

    // Register-file view: address 0 is the constant ID, not storage.
    function automatic logic [7:0] reg_val(input logic [ADDR_W-1:0] a);
        if (a == '0) begin
            return ID_VAL;
        end
        return regs[a];
    endfunction

    // Decode the incoming byte and the current pointer.
    always_comb begin
        byte_ev     = cs_i & mosi_vld_i;
        cmd_addr    = mosi_byte_i[ADDR_W-1:0];
        cmd_illegal = |(mosi_byte_i[5:0] & HI_MASK);
        addr_inc    = addr + 1'b1;
        reg_we      = byte_ev && (state == S_WRITE) && (addr != '0);
        rd_data_o   = reg_val(rd_addr_i);
    end

    assign state_o = state;

    // Frame sequencer: command parsing, pointer update and MISO/strobe outputs.
    always_ff @(posedge Clk_p_w or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            addr        <= '0;
            ai          <= 1'b0;
            miso_en_o   <= 1'b0;
            miso_byte_o <= 8'h00;
            wr_stb_o    <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= 8'h00;
        end else begin
            wr_stb_o <= 1'b0;
            if (!cs_i) begin
                // Deselect aborts the frame. miso_byte_o keeps its last value.
                state     <= S_IDLE;
                miso_en_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_ev) begin
                            addr <= cmd_addr;
                            ai   <= mosi_byte_i[6];
                            if (cmd_illegal) begin
                                state <= S_DISCARD;
                            end else if (mosi_byte_i[7]) begin
                                state <= S_WRITE;
                            end else begin
                                state       <= S_READ;
                                miso_byte_o <= reg_val(cmd_addr);
                                miso_en_o   <= 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (byte_ev) begin
                            if (addr != '0) begin
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= addr;
                                wr_data_o <= mosi_byte_i;
                            end
                            if (ai) begin
                                addr <= addr_inc;
                            end
                        end
                    end
                    S_READ: begin
                        // The incoming byte is a dummy. It only paces the next MISO byte.
                        if (byte_ev) begin
                            if (ai) begin
                                addr        <= addr_inc;
                                miso_byte_o <= reg_val(addr_inc);
                            end else begin
                                miso_byte_o <= reg_val(addr);
                            end
                        end
                    end
                    default: begin
                        // DISCARD: ignore bytes until deselect.
                        miso_en_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register storage. Reset clears every entry.
    always_ff @(posedge Clk_p_w or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (reg_we) begin
            regs[addr] <= mosi_byte_i;
        end
    end

`ifdef SPI_REG_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Count illegal command bytes, saturating at 8'hFF.
    always_ff @(posedge Clk_p_w or posedge rst_i) begin
        if (rst_i) begin
            err_cnt <= 8'h00;
        end else if (byte_ev && (state == S_IDLE) && cmd_illegal && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl (ADDR_W=4, ID_VAL=8'hA5).
// Expected write strobes go into exp_q when write bytes are driven. A monitor
// pops an entry from exp_q for each wr_stb_o pulse and compares it.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst;
    logic       cs;
    logic       vld;
    logic [7:0] mosi;
    logic       miso_en;
    logic [7:0] miso_byte;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] err_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    spi_reg_ctrl dut (
        .Clk_p_w    (clk),
        .rst_i      (rst),
        .cs_i       (cs),
        .mosi_vld_i (vld),
        .mosi_byte_i(mosi),
        .miso_en_o  (miso_en),
        .miso_byte_o(miso_byte),
        .wr_stb_o   (wr_stb),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .err_cnt_o  (err_cnt),
        .state_o    (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: values change on the falling edge and are sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        cs   = 1'b1;
        vld  = 1'b1;
        mosi = b;
        @(negedge clk);
        vld  = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs  = 1'b0;
        vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    // Scoreboard monitor for write strobes
    always @(negedge clk) begin
        if (!rst && wr_stb) begin
            check("wr_stb_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("wr_stb_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    logic [7:0] rnd [4];
    logic [7:0] exp_err;

    initial begin
        rst = 1'b1; cs = 1'b0; vld = 1'b0; mosi = 8'h00; rd_addr = 4'd0;
`ifdef SPI_REG_ERR_CNT_EN
        exp_err = 8'h01;
`else
        exp_err = 8'h00;
`endif
        do_reset();

        // Reset state
        check("rst_miso_en", miso_en, 0);
        check("rst_miso_byte", miso_byte, 8'h00);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_state", state, 0);
        peek(4'd0, 8'hA5, "rst_rd_id");
        peek(4'd5, 8'h00, "rst_rd_reg5");

        // Read frame of register 0
        send_byte(8'h00);
        check("rd0_miso_en", miso_en, 1);
        check("rd0_miso_byte", miso_byte, 8'hA5);
        send_byte(8'h00);
        check("rd0_miso_byte_reload", miso_byte, 8'hA5);
        end_frame();
        check("rd0_end_miso_en", miso_en, 0);
        check("rd0_end_state", state, 0);
        check("rd0_end_miso_hold", miso_byte, 8'hA5);

        // Auto-increment write from address 3
        send_byte(8'hC3);
        exp_q.push_back({4'd3, 8'h11});
        send_byte(8'h11);
        exp_q.push_back({4'd4, 8'h22});
        send_byte(8'h22);
        end_frame();
        peek(4'd4, 8'h22, "wr_rd_reg4");
        peek(4'd3, 8'h11, "wr_rd_reg3");
        check("wr_q_drained", exp_q.size(), 0);

        // Pointer wrap: address 15 is written, then the write to 0 is dropped
        send_byte(8'hCF);
        exp_q.push_back({4'd15, 8'hAA});
        send_byte(8'hAA);
        send_byte(8'hBB);
        end_frame();
        peek(4'd15, 8'hAA, "wrap_reg15");
        peek(4'd0, 8'hA5, "wrap_reg0_id");
        check("wrap_q_drained", exp_q.size(), 0);

        // Auto-increment read across the wrap
        send_byte(8'h4E);
        check("rdai_byte0", miso_byte, 8'h00);
        send_byte(8'h00);
        check("rdai_byte1", miso_byte, 8'hAA);
        send_byte(8'h00);
        check("rdai_byte2", miso_byte, 8'hA5);
        send_byte(8'h00);
        check("rdai_byte3", miso_byte, 8'h00);
        check("rdai_miso_en", miso_en, 1);
        end_frame();

        // Abort: deselect coinciding with a data byte drops the byte
        send_byte(8'h85);
        @(negedge clk);
        cs = 1'b0; vld = 1'b1; mosi = 8'h77;
        @(negedge clk);
        vld = 1'b0;
        check("abort_wr_stb", wr_stb, 0);
        check("abort_state", state, 0);
        peek(4'd5, 8'h00, "abort_reg5");

        // Random-data write frame read back over MISO and the user port
        send_byte(8'hC8);
        for (int i = 0; i < 4; i++) begin
            rnd[i] = 8'($urandom_range(0, 255));
            exp_q.push_back({4'(8 + i), rnd[i]});
            send_byte(rnd[i]);
        end
        end_frame();
        check("rnd_q_drained", exp_q.size(), 0);
        send_byte(8'h48);
        check("rnd_miso0", miso_byte, rnd[0]);
        for (int i = 1; i < 4; i++) begin
            send_byte(8'h00);
            check("rnd_miso", miso_byte, rnd[i]);
        end
        end_frame();
        peek(4'd11, rnd[3], "rnd_rd_reg11");

        // Illegal command is discarded
        send_byte(8'h30);
        check("ill_state", state, 3);
        check("ill_miso_en", miso_en, 0);
        send_byte(8'h01);
        check("ill_wr_stb", wr_stb, 0);
        check("ill_miso_en2", miso_en, 0);
        check("ill_err_cnt", err_cnt, exp_err);
        end_frame();
        check("ill_end_state", state, 0);
        check("ill_q_empty", exp_q.size(), 0);

        // Reset clears the counter and the register file
        do_reset();
        check("rst2_err_cnt", err_cnt, 0);
        peek(4'd4, 8'h00, "rst2_reg4");
        peek(4'd15, 8'h00, "rst2_reg15");

        // Report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
